// File: rtl/palette_loader.sv
`default_nettype none
// ============================================================================
// Module   : palette_loader
// Brief    : Stages a 4-colour palette from the ioctl channel and commits it to
//            the live table on vblank. Does the 2-bit to RGB888 pixel lookup.
//            Optional flicker blend is built when PALETTE_BLEND_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module palette_loader #(
    parameter logic [5:0]  FILE_INDEX      = 6'd3,
    parameter logic [95:0] DEFAULT_PALETTE = 96'h384052_386B82_6BA378_87BA6B
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        enable,
    input  logic        vblank,
    input  logic        ce_pix,
    input  logic [1:0]  pixel,
    input  logic [1:0]  prev_pixel,
    input  logic        blend_en,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        pal_valid
);

    localparam int c_NUM_BYTES = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

    state_t      r_state;
    logic [11:0] r_mask;
    logic [7:0]  r_shadow [c_NUM_BYTES];
    logic [23:0] r_live [4];
    logic        r_pal_valid;
    logic        r_match_d;
    logic        r_vblank_d;

    logic        w_match;
    logic        w_match_rise;
    logic        w_vb_rise;
    logic        w_byte_ok;
    logic        w_accept;
    logic [3:0]  w_addr;
    logic [11:0] w_mask_set;
    logic [23:0] w_shadow_entry [4];
    logic [23:0] w_col [4];
    logic [23:0] w_cur;
    logic [23:0] w_out;
    logic        w_unused;

    assign w_match      = ioctl_download && (ioctl_index[5:0] == FILE_INDEX);
    assign w_match_rise = w_match && !r_match_d;
    assign w_vb_rise    = vblank && !r_vblank_d;
    assign w_addr       = ioctl_addr[3:0];
    assign w_byte_ok    = ioctl_wr && w_match && (ioctl_addr < 25'd12);
    assign w_accept     = w_byte_ok &&
                          ((r_state == ST_LOAD) || ((r_state == ST_IDLE) && w_match_rise));
    assign w_mask_set   = w_accept ? (12'b1 << w_addr) : 12'b0;

    // Holding the HPS here keeps the uncommitted shadow intact until vblank.
    assign ioctl_wait   = (r_state == ST_PENDING) && w_match;
    assign pal_valid    = r_pal_valid;

    always_ff @(posedge clk_sys) begin
        if (w_accept) begin
            r_shadow[w_addr] <= ioctl_dout;
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_entry
        assign w_shadow_entry[n] = {r_shadow[3*n], r_shadow[3*n+1], r_shadow[3*n+2]};
        assign w_col[n] = (enable && r_pal_valid) ? r_live[n] : DEFAULT_PALETTE[24*n +: 24];
    end

    // Download history resets high so a download still running across reset
    // never looks like a fresh start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mask      <= 12'b0;
            r_pal_valid <= 1'b0;
            r_match_d   <= 1'b1;
            r_vblank_d  <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                r_live[n] <= DEFAULT_PALETTE[24*n +: 24];
            end
        end else begin
            r_match_d  <= w_match;
            r_vblank_d <= vblank;
            case (r_state)
                ST_IDLE: begin
                    if (w_match_rise) begin
                        r_state <= ST_LOAD;
                        r_mask  <= w_mask_set;
                    end
                end
                ST_LOAD: begin
                    r_mask <= r_mask | w_mask_set;
                    if (!w_match) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_state <= (&r_mask) ? ST_PENDING : ST_IDLE;
                end
                ST_PENDING: begin
                    if (w_vb_rise) begin
                        for (int n = 0; n < 4; n++) begin
                            r_live[n] <= w_shadow_entry[n];
                        end
                        r_pal_valid <= 1'b1;
                        r_mask      <= 12'b0;
                        r_state     <= w_match ? ST_LOAD : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_cur = w_col[pixel];

`ifdef PALETTE_BLEND_EN
    logic [23:0] w_prev;
    logic [23:0] w_avg;

    assign w_prev = w_col[prev_pixel];

    for (genvar k = 0; k < 3; k++) begin : g_blend
        logic [8:0] w_sum;
        assign w_sum = {1'b0, w_cur[8*k +: 8]} + {1'b0, w_prev[8*k +: 8]};
        assign w_avg[8*k +: 8] = w_sum[8:1];
    end

    assign w_out    = blend_en ? w_avg : w_cur;
    assign w_unused = &{1'b0, ioctl_index[7:6]};
`else
    assign w_out    = w_cur;
    assign w_unused = &{1'b0, ioctl_index[7:6], blend_en, prev_pixel};
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
        end else if (ce_pix) begin
            {red, green, blue} <= w_out;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_palette_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_palette_loader
// Brief    : Directed self-checking bench for palette_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_palette_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        enable;
    logic        vblank;
    logic        ce_pix;
    logic [1:0]  pixel;
    logic [1:0]  prev_pixel;
    logic        blend_en;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        pal_valid;

    int total = 0;
    int bad   = 0;

    palette_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .enable         (enable),
        .vblank         (vblank),
        .ce_pix         (ce_pix),
        .pixel          (pixel),
        .prev_pixel     (prev_pixel),
        .blend_en       (blend_en),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .pal_valid      (pal_valid)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic end_download();
        ioctl_download = 1'b0;
        tick(3);
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
    endtask

    task automatic lookup(input logic [1:0] p);
        pixel  = p;
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        total++;
        if ({red, green, blue} !== 24'h000000) begin
            bad++;
            $display("FAIL reset_rgb got %h want 000000", {red, green, blue});
        end
        total++;
        if (pal_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got %b want 0", pal_valid);
        end
        total++;
        if (ioctl_wait !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait got %b want 0", ioctl_wait);
        end
        reset = 1'b0;
        tick(2);
        enable = 1'b1;
        lookup(2'd2);
        total++;
        if ({red, green, blue} !== 24'h386B82) begin
            bad++;
            $display("FAIL default_pix2 got %h want 386B82", {red, green, blue});
        end
        total++;
        if (pal_valid !== 1'b0) begin
            bad++;
            $display("FAIL default_valid got %b want 0", pal_valid);
        end
    endtask

    task automatic test_partial();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd3;
        for (int a = 0; a <= 10; a++) write_byte(25'(a), 8'hC0 + 8'(a));
        end_download();
        vblank_pulse();
        total++;
        if (pal_valid !== 1'b0) begin
            bad++;
            $display("FAIL partial_valid got %b want 0", pal_valid);
        end
        lookup(2'd1);
        total++;
        if ({red, green, blue} !== 24'h6BA378) begin
            bad++;
            $display("FAIL partial_rgb got %h want 6BA378", {red, green, blue});
        end
        // A full-length ROM download must not touch the palette.
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        for (int a = 0; a < 12; a++) write_byte(25'(a), 8'h11);
        total++;
        if (ioctl_wait !== 1'b0) begin
            bad++;
            $display("FAIL rom_wait got %b want 0", ioctl_wait);
        end
        end_download();
        vblank_pulse();
        total++;
        if (pal_valid !== 1'b0) begin
            bad++;
            $display("FAIL rom_valid got %b want 0", pal_valid);
        end
    endtask

    task automatic test_download();
        // First byte rides on the same cycle as the download rising edge.
        ioctl_download = 1'b1;
        ioctl_index    = 8'd3;
        write_byte(25'd0, 8'hFF);
        write_byte(25'd1, 8'h00);
        write_byte(25'd2, 8'h00);
        write_byte(25'd3, 8'h00);
        write_byte(25'd4, 8'hFF);
        write_byte(25'd5, 8'h00);
        write_byte(25'd6, 8'h00);
        write_byte(25'd7, 8'h00);
        write_byte(25'd8, 8'hFF);
        write_byte(25'd9, 8'h99);
        write_byte(25'd10, 8'h20);
        write_byte(25'd11, 8'h30);
        write_byte(25'd9, 8'h10);
        write_byte(25'd12, 8'hEE);
        write_byte(25'h10, 8'hEE);
        write_byte(25'h13, 8'hEE);
        end_download();
        total++;
        if (pal_valid !== 1'b0) begin
            bad++;
            $display("FAIL pending_valid got %b want 0", pal_valid);
        end
        lookup(2'd3);
        total++;
        if ({red, green, blue} !== 24'h384052) begin
            bad++;
            $display("FAIL pending_rgb got %h want 384052", {red, green, blue});
        end
        vblank_pulse();
        total++;
        if (pal_valid !== 1'b1) begin
            bad++;
            $display("FAIL commit_valid got %b want 1", pal_valid);
        end
        lookup(2'd3);
        total++;
        if ({red, green, blue} !== 24'h102030) begin
            bad++;
            $display("FAIL custom_pix3 got %h want 102030", {red, green, blue});
        end
        lookup(2'd0);
        total++;
        if ({red, green, blue} !== 24'hFF0000) begin
            bad++;
            $display("FAIL custom_pix0 got %h want FF0000", {red, green, blue});
        end
        lookup(2'd1);
        total++;
        if ({red, green, blue} !== 24'h00FF00) begin
            bad++;
            $display("FAIL custom_pix1 got %h want 00FF00", {red, green, blue});
        end
        enable = 1'b0;
        lookup(2'd0);
        total++;
        if ({red, green, blue} !== 24'h87BA6B) begin
            bad++;
            $display("FAIL disabled_pix0 got %h want 87BA6B", {red, green, blue});
        end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd3;
        tick();
        for (int a = 0; a < 12; a++) write_byte(25'(a), 8'h01 + 8'(a));
        end_download();
        total++;
        if (ioctl_wait !== 1'b0) begin
            bad++;
            $display("FAIL idle_pending_wait got %b want 0", ioctl_wait);
        end
        ioctl_download = 1'b1;
        #1;
        total++;
        if (ioctl_wait !== 1'b1) begin
            bad++;
            $display("FAIL wait_assert got %b want 1", ioctl_wait);
        end
        write_byte(25'd0, 8'h55);
        tick(3);
        total++;
        if (ioctl_wait !== 1'b1) begin
            bad++;
            $display("FAIL wait_hold got %b want 1", ioctl_wait);
        end
        lookup(2'd0);
        total++;
        if ({red, green, blue} !== 24'hFF0000) begin
            bad++;
            $display("FAIL precommit_pix0 got %h want FF0000", {red, green, blue});
        end
        // Commit and lookup share a cycle: the lookup sees the old table.
        vblank = 1'b1;
        pixel  = 2'd3;
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
        vblank = 1'b0;
        total++;
        if ({red, green, blue} !== 24'h102030) begin
            bad++;
            $display("FAIL same_cycle_rgb got %h want 102030", {red, green, blue});
        end
        total++;
        if (ioctl_wait !== 1'b0) begin
            bad++;
            $display("FAIL wait_release got %b want 0", ioctl_wait);
        end
        lookup(2'd0);
        total++;
        if ({red, green, blue} !== 24'h010203) begin
            bad++;
            $display("FAIL second_pix0 got %h want 010203", {red, green, blue});
        end
        lookup(2'd3);
        total++;
        if ({red, green, blue} !== 24'h0A0B0C) begin
            bad++;
            $display("FAIL second_pix3 got %h want 0A0B0C", {red, green, blue});
        end
        for (int n = 0; n < 4; n++) begin
            write_byte(25'(3*n),   8'h21 + 8'(16*n));
            write_byte(25'(3*n+1), 8'h22 + 8'(16*n));
            write_byte(25'(3*n+2), 8'h23 + 8'(16*n));
        end
        end_download();
        vblank_pulse();
        lookup(2'd2);
        total++;
        if ({red, green, blue} !== 24'h414243) begin
            bad++;
            $display("FAIL third_pix2 got %h want 414243", {red, green, blue});
        end
    endtask

    task automatic test_blend();
        enable     = 1'b0;
        blend_en   = 1'b1;
        prev_pixel = 2'd3;
        lookup(2'd0);
`ifdef PALETTE_BLEND_EN
        total++;
        if ({red, green, blue} !== 24'h5F7D5E) begin
            bad++;
            $display("FAIL blend_rgb got %h want 5F7D5E", {red, green, blue});
        end
`else
        total++;
        if ({red, green, blue} !== 24'h87BA6B) begin
            bad++;
            $display("FAIL blend_ignored got %h want 87BA6B", {red, green, blue});
        end
`endif
        blend_en = 1'b0;
        lookup(2'd0);
        total++;
        if ({red, green, blue} !== 24'h87BA6B) begin
            bad++;
            $display("FAIL blend_off got %h want 87BA6B", {red, green, blue});
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd3;
        tick();
        for (int a = 0; a < 6; a++) write_byte(25'(a), 8'hA0 + 8'(a));
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd6;
        ioctl_dout = 8'hA6;
        reset      = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        total++;
        if ({red, green, blue} !== 24'h000000) begin
            bad++;
            $display("FAIL midreset_rgb got %h want 000000", {red, green, blue});
        end
        total++;
        if (pal_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_valid got %b want 0", pal_valid);
        end
        total++;
        if (ioctl_wait !== 1'b0) begin
            bad++;
            $display("FAIL midreset_wait got %b want 0", ioctl_wait);
        end
        reset = 1'b0;
        tick();
        // Rest of the interrupted download, even complete, must be dropped.
        for (int a = 0; a < 12; a++) write_byte(25'(a), 8'hB0 + 8'(a));
        end_download();
        vblank_pulse();
        total++;
        if (pal_valid !== 1'b0) begin
            bad++;
            $display("FAIL postreset_valid got %b want 0", pal_valid);
        end
        lookup(2'd0);
        total++;
        if ({red, green, blue} !== 24'h87BA6B) begin
            bad++;
            $display("FAIL postreset_pix0 got %h want 87BA6B", {red, green, blue});
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        enable         = 1'b0;
        vblank         = 1'b0;
        ce_pix         = 1'b0;
        pixel          = 2'd0;
        prev_pixel     = 2'd0;
        blend_en       = 1'b0;

        test_reset();
        test_partial();
        test_download();
        test_back_to_back();
        test_blend();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/palette_loader.md
# palette_loader

Receives a custom 4-colour palette file streamed over the HPS ioctl download channel and stages it in a shadow buffer. It commits the palette to the live table on the next vertical blank and performs the per-pixel 2-bit to RGB888 lookup for the video mixer. It sits in the emu top level between hps_io and video_mixer. It replaces the fixed palette constant and feeds red/green/blue.

## Interface
Parameters:
- FILE_INDEX, 3 — value of ioctl_index[5:0] that identifies a palette download.
- DEFAULT_PALETTE, 96'h384052_386B82_6BA378_87BA6B — built-in colours; entry n is at bits [24n+23:24n], stored as {R,G,B}.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download file index.
- ioctl_wr  in  1  byte strobe, one clk_sys cycle wide.
- ioctl_addr  in  25  byte address within the file.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stalls the HPS while an earlier palette is still uncommitted.
- enable  in  1  custom palette selected (OSD option).
- vblank  in  1  vertical blank from the core.
- ce_pix  in  1  pixel clock enable.
- pixel  in  2  current pixel index.
- prev_pixel  in  2  same pixel from the previous frame.
- blend_en  in  1  flicker-blend request.
- red, green, blue  out  8 each  registered colour output.
- pal_valid  out  1  a custom palette has been committed since reset.

## Operation
- Matching download: ioctl_download=1 and ioctl_index[5:0]==FILE_INDEX.
- File format: 12 bytes. Byte at address a belongs to entry a/3; component a%3 selects the channel (0=R, 1=G, 2=B).
- State machine: IDLE, LOAD, CHECK, PENDING.
  - IDLE -> LOAD on a matching download rising; the 12-bit written mask is cleared.
  - LOAD: each ioctl_wr with ioctl_addr<12 writes the shadow byte and sets its mask bit. Writes with ioctl_addr>=12 are ignored. A rewrite of the same address overwrites the byte.
  - LOAD -> CHECK on ioctl_download falling.
  - CHECK -> PENDING if the mask is all ones. Otherwise CHECK -> IDLE: the shadow is discarded and the live table is unchanged.
  - PENDING: on a rising edge of vblank (0->1 between consecutive cycles), all 12 bytes are copied shadow -> live in one cycle, pal_valid<=1, and the FSM -> IDLE.
- ioctl_wait=1 whenever a matching download is active while the FSM is in PENDING. It drops in the cycle after the commit; the FSM then enters LOAD for the new file. No shadow byte is overwritten before its commit.
- Non-matching downloads (ROM, index 0/1) are ignored in every state.
- Colour select: c[n] = (enable && pal_valid) ? live[n] : DEFAULT_PALETTE entry n. enable is sampled per pixel and takes effect immediately.
- Blend: per channel, out = ({1'b0,c[pixel]} + c[prev_pixel]) >> 1. The sum is 9 bits and the result is truncated to 8 bits.

## Timing
- Reset values:
  - FSM = IDLE, mask = 0.
  - live table = DEFAULT_PALETTE; shadow is don't-care.
  - pal_valid = 0, ioctl_wait = 0.
  - red/green/blue = 0.
  - Registered vblank = 0, so a vblank already high when reset releases is not an edge.
- Reset mid-download aborts the load. The FSM waits in IDLE; the remainder of that download is ignored because the download-rising condition is not met.
- Shadow write: the byte is visible in the shadow 1 cycle after ioctl_wr.
- CHECK lasts exactly 1 cycle.
- Commit latency: live changes 1 cycle after the vblank rising edge is detected.
- Lookup latency: red/green/blue update on the clock edge where ce_pix=1, using the pixel values present in that cycle. Outputs hold when ce_pix=0.
- Simultaneous commit and lookup in one cycle: the lookup uses the pre-commit table.
- ioctl_wr in the same cycle as the download rising edge is accepted as the first byte.

## Configuration
- PALETTE_BLEND_EN defined: the blend datapath is built and blend_en=1 selects the averaged output.
- PALETTE_BLEND_EN undefined: blend_en and prev_pixel are ignored and out = c[pixel] on every ce_pix. No adder logic is synthesised.

## Test plan
- Reset, enable=1, pixel=2, ce_pix pulse -> RGB = 38,6B,82 and pal_valid=0.
- Download 12 bytes FF,00,00, 00,FF,00, 00,00,FF, 10,20,30, then a vblank rise -> pal_valid=1. pixel=3 gives 10,20,30; pixel=0 with enable=0 gives 87,BA,6B.
- Download only addresses 0..10 -> FSM returns to IDLE, pal_valid stays 0 and the output is still the default.
- Start a second matching download while PENDING -> ioctl_wait=1 until the next vblank rise. The first palette is committed before any new byte is accepted.
- With PALETTE_BLEND_EN, blend_en=1, default palette, pixel=0, prev_pixel=3 -> RGB = 5F,7D,5E.
- Assert reset during byte 6 of a download -> live stays default, pal_valid=0, ioctl_wait=0 and the RGB outputs are 0.
